// File: rtl/instr_fetch_unit_if.sv
// Instruction fetch unit bus bundle: memory read port, instruction hand-off
// to execute, redirect/start control and status outputs.
interface instr_fetch_unit_if #(
   parameter int ADDR_W = 16
);
   logic              start;
   logic              mem_req;
   logic [ADDR_W-1:0] mem_addr;
   logic              mem_ack;
   logic [31:0]       mem_rdata;
   logic [31:0]       ir;
   logic              ir_valid;
   logic              ir_ready;
   logic              redirect;
   logic [ADDR_W-1:0] redirect_pc;
   logic [ADDR_W-1:0] pc;
   logic              halted;
   logic              busy;
   logic [31:0]       instr_count;

   // Fetch unit side
   modport master (
      input  start, mem_ack, mem_rdata, ir_ready, redirect, redirect_pc,
      output mem_req, mem_addr, ir, ir_valid, pc, halted, busy, instr_count
   );

   // Memory / execute / control side
   modport slave (
      output start, mem_ack, mem_rdata, ir_ready, redirect, redirect_pc,
      input  mem_req, mem_addr, ir, ir_valid, pc, halted, busy, instr_count
   );
endinterface

// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: reads words from instruction memory over a req/ack
// handshake, holds each word on ir for the execute stage (valid/ready), tracks
// the program counter, follows redirects and stops after a HALT is consumed.
module instr_fetch_unit #(
   parameter int                ADDR_W   = 16,
   parameter logic [ADDR_W-1:0] RESET_PC = '0,
   parameter logic [4:0]        HALT_OP  = 5'b11111
) (
   input  logic                 clk,
   input  logic                 clr,
   instr_fetch_unit_if.master   ifu
);

   typedef enum logic [1:0] {
      S_IDLE,
      S_FETCH,
      S_HOLD,
      S_HALT
   } state_t;

   state_t            r_state;
   logic [ADDR_W-1:0] r_fetch_pc;
   logic              r_mem_req;
   logic [ADDR_W-1:0] r_mem_addr;
   logic [31:0]       r_ir;
   logic              r_ir_valid;
   logic [ADDR_W-1:0] r_pc;
   logic              r_halted;
   logic              r_busy;
   logic [31:0]       r_instr_count;
   logic              r_squash;

   logic              w_is_halt;
   logic [ADDR_W-1:0] w_target;

   // Opcode of the held word decides where a consumed instruction leads.
   assign w_is_halt = (r_ir[31:27] == HALT_OP);
   // Address of the next request: a same-cycle redirect beats the stored fetch_pc.
   assign w_target  = ifu.redirect ? ifu.redirect_pc : r_fetch_pc;

   // Fetch control FSM; every output is a register updated here.
   always_ff @(posedge clk or posedge clr) begin
      if (clr) begin
         r_state       <= S_IDLE;
         r_fetch_pc    <= RESET_PC;
         r_mem_req     <= 1'b0;
         r_mem_addr    <= RESET_PC;
         r_ir          <= 32'd0;
         r_ir_valid    <= 1'b0;
         r_pc          <= RESET_PC;
         r_halted      <= 1'b0;
         r_busy        <= 1'b0;
         r_instr_count <= 32'd0;
         r_squash      <= 1'b0;
      end else begin
         // A redirect always retargets the next fetch; states below may
         // additionally act on it.
         if (ifu.redirect) begin
            r_fetch_pc <= ifu.redirect_pc;
         end

         case (r_state)
            S_IDLE: begin
               if (ifu.start) begin
                  r_state    <= S_FETCH;
                  r_busy     <= 1'b1;
                  r_mem_req  <= 1'b1;
                  r_mem_addr <= w_target;
               end
            end

            S_FETCH: begin
               if (ifu.mem_ack) begin
                  if (r_squash || ifu.redirect) begin
                     // Returned word belongs to a stale path: drop it and
                     // re-issue at the current target; mem_req stays high.
                     r_squash   <= 1'b0;
                     r_mem_addr <= w_target;
                  end else begin
                     r_ir       <= ifu.mem_rdata;
                     r_pc       <= r_mem_addr;
                     r_fetch_pc <= r_mem_addr + ADDR_W'(1);
                     r_ir_valid <= 1'b1;
                     r_mem_req  <= 1'b0;
                     r_state    <= S_HOLD;
                  end
               end else if (ifu.redirect) begin
                  // Address must stay stable while the request is pending,
                  // so remember to discard its data instead.
                  r_squash <= 1'b1;
               end
            end

            S_HOLD: begin
               if (ifu.ir_ready) begin
                  r_instr_count <= r_instr_count + 32'd1;
                  r_ir_valid    <= 1'b0;
                  if (w_is_halt) begin
                     r_state  <= S_HALT;
                     r_busy   <= 1'b0;
                     r_halted <= 1'b1;
                  end else begin
                     r_state    <= S_FETCH;
                     r_mem_req  <= 1'b1;
                     r_mem_addr <= w_target;
                  end
               end else if (ifu.redirect) begin
                  // Held word is on the abandoned path: drop it uncounted.
                  r_ir_valid <= 1'b0;
                  r_state    <= S_FETCH;
                  r_mem_req  <= 1'b1;
                  r_mem_addr <= ifu.redirect_pc;
               end
            end

            S_HALT: begin
               if (ifu.start) begin
                  r_halted   <= 1'b0;
                  r_state    <= S_FETCH;
                  r_busy     <= 1'b1;
                  r_mem_req  <= 1'b1;
                  r_mem_addr <= w_target;
               end
            end
         endcase
      end
   end

   assign ifu.mem_req     = r_mem_req;
   assign ifu.mem_addr    = r_mem_addr;
   assign ifu.ir          = r_ir;
   assign ifu.ir_valid    = r_ir_valid;
   assign ifu.pc          = r_pc;
   assign ifu.halted      = r_halted;
   assign ifu.busy        = r_busy;
   assign ifu.instr_count = r_instr_count;

endmodule
